wb_arbiter: RTL

Write-back arbiter: the writer side of the register-file write port consumed by the RF stage.
- Collects completed results from the ALU pipe and the load/store pipe.
- Buffers each result in a per-source FIFO.
- Drives exactly one physical-register write per cycle (write_register_flag/index/data) plus a matching ROB completion pulse.
- Sits between the execute/memory stages and the RF/ROB.

---
 rtl/wb_arbiter_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 57 +++++
 rtl/wb_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the write-back arbiter slice.
// Entry bundle, source encoding and default widths.
package wb_arbiter_pkg;

  localparam int WB_ROBINDEX = 6;
  localparam int WB_PREG_W   = 6;
  localparam int WB_DEPTH    = 4;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef struct packed {
    logic [WB_ROBINDEX-1:0] rob;
    logic [WB_PREG_W-1:0]   preg;
    logic [31:0]            data;
    logic                   regwrite;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO for the write-back arbiter.
// Pointers carry one extra bit so the count reaches DEPTH.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push_i,
  input  logic          pop_i,
  input  wb_entry_t     wdata_i,
  output wb_entry_t     rdata_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  wb_entry_t mem_q [DEPTH];

  logic [CW-1:0] wr_q, wr_d;
  logic [CW-1:0] rd_q, rd_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full    = (count_o == FULLC);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q + CW'(do_push);
    rd_d = rd_q + CW'(do_pop);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU/MEM result FIFOs into one RF write + ROB pulse.
// Define WB_BYPASS_EN for 1-edge latency when both FIFOs are empty.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH    = WB_DEPTH,
  parameter int ROBINDEX = WB_ROBINDEX,
  parameter int PREG_W   = WB_PREG_W
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FREEZE,
  input  logic                ALU_valid,
  output logic                ALU_ready,
  input  logic [ROBINDEX-1:0] ALU_rob,
  input  logic [PREG_W-1:0]   ALU_preg,
  input  logic [31:0]         ALU_data,
  input  logic                ALU_regwrite,
  input  logic                MEM_valid,
  output logic                MEM_ready,
  input  logic [ROBINDEX-1:0] MEM_rob,
  input  logic [PREG_W-1:0]   MEM_preg,
  input  logic [31:0]         MEM_data,
  input  logic                MEM_regwrite,
  output logic                write_register_flag,
  output logic [PREG_W-1:0]   write_register_index,
  output logic [31:0]         write_register_data,
  output logic                ROB_complete,
  output logic [ROBINDEX-1:0] ROB_complete_idx
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  wb_entry_t alu_in, mem_in;
  wb_entry_t alu_head, mem_head;
  wb_entry_t sel;

  logic [CW-1:0] alu_cnt, mem_cnt;
  logic alu_empty, mem_empty;
  logic alu_acc, mem_acc;
  logic gnt_alu, gnt_mem;
  logic byp_alu, byp_mem;
  logic sel_any;

  src_e last_q, last_d;

  logic                   flag_q, flag_d;
  logic                   cmp_q, cmp_d;
  logic [WB_ROBINDEX-1:0] idx_q, idx_d;
  logic [WB_PREG_W-1:0]   preg_q, preg_d;
  logic [31:0]            data_q, data_d;

  assign alu_in = '{
    rob:      WB_ROBINDEX'(ALU_rob),
    preg:     WB_PREG_W'(ALU_preg),
    data:     ALU_data,
    regwrite: ALU_regwrite
  };

  assign mem_in = '{
    rob:      WB_ROBINDEX'(MEM_rob),
    preg:     WB_PREG_W'(MEM_preg),
    data:     MEM_data,
    regwrite: MEM_regwrite
  };

  assign ALU_ready = RESET && !FREEZE && (alu_cnt < FULLC);
  assign MEM_ready = RESET && !FREEZE && (mem_cnt < FULLC);
  assign alu_acc   = ALU_valid && ALU_ready;
  assign mem_acc   = MEM_valid && MEM_ready;

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push_i  (alu_acc && !byp_alu),
    .pop_i   (gnt_alu),
    .wdata_i (alu_in),
    .rdata_o (alu_head),
    .empty_o (alu_empty),
    .count_o (alu_cnt)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push_i  (mem_acc && !byp_mem),
    .pop_i   (gnt_mem),
    .wdata_i (mem_in),
    .rdata_o (mem_head),
    .empty_o (mem_empty),
    .count_o (mem_cnt)
  );

  // Grant the FIFO heads; a frozen cycle grants nothing.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    byp_alu = 1'b0;
    byp_mem = 1'b0;
    if (!FREEZE) begin
      if (!alu_empty && !mem_empty) begin
        if (last_q == SRC_MEM) gnt_alu = 1'b1;
        else                   gnt_mem = 1'b1;
      end else if (!alu_empty) begin
        gnt_alu = 1'b1;
      end else if (!mem_empty) begin
        gnt_mem = 1'b1;
      end else begin
`ifdef WB_BYPASS_EN
        if (alu_acc && (!mem_acc || last_q == SRC_MEM)) begin
          byp_alu = 1'b1;
        end else if (mem_acc) begin
          byp_mem = 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    sel = alu_in;
    unique case (1'b1)
      gnt_alu: sel = alu_head;
      gnt_mem: sel = mem_head;
      byp_mem: sel = mem_in;
      default: sel = alu_in;
    endcase
  end

  assign sel_any = gnt_alu | gnt_mem | byp_alu | byp_mem;

  always_comb begin
    last_d = last_q;
    flag_d = 1'b0;
    cmp_d  = 1'b0;
    idx_d  = idx_q;
    preg_d = preg_q;
    data_d = data_q;
    if (sel_any) begin
      last_d = (gnt_alu || byp_alu) ? SRC_ALU : SRC_MEM;
      cmp_d  = 1'b1;
      flag_d = sel.regwrite;
      idx_d  = sel.rob;
      preg_d = sel.preg;
      data_d = sel.data;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_q <= SRC_MEM;
      flag_q <= 1'b0;
      cmp_q  <= 1'b0;
      idx_q  <= '0;
      preg_q <= '0;
      data_q <= '0;
    end else begin
      last_q <= last_d;
      flag_q <= flag_d;
      cmp_q  <= cmp_d;
      idx_q  <= idx_d;
      preg_q <= preg_d;
      data_q <= data_d;
    end
  end

  assign write_register_flag  = flag_q;
  assign write_register_index = PREG_W'(preg_q);
  assign write_register_data  = data_q;
  assign ROB_complete         = cmp_q;
  assign ROB_complete_idx     = ROBINDEX'(idx_q);

endmodule
